// File: rtl/iir_channel_scheduler_if.sv
// Frame-in / per-channel-result bus of the IIR channel scheduler.
// The scheduler connects through the slave modport; the frame source and result sink use master.
interface iir_channel_scheduler_if #(
  parameter int Q_IN = 32,
  parameter int N_CH = 8
);
  logic                   in_valid;
  logic [N_CH*Q_IN-1:0]   in_data;
  logic                   in_ready;
  logic [N_CH-1:0]        ch_en;
  logic                   state_clr;
  logic                   out_valid;
  logic [3:0]             out_ch;
  logic signed [Q_IN-1:0] out_data;
  logic                   out_last;
  logic [15:0]            overrun_cnt;

  modport master (
    output in_valid, in_data, ch_en, state_clr,
    input  in_ready, out_valid, out_ch, out_data, out_last, overrun_cnt
  );

  modport slave (
    input  in_valid, in_data, ch_en, state_clr,
    output in_ready, out_valid, out_ch, out_data, out_last, overrun_cnt
  );
endinterface

// File: rtl/iir_channel_scheduler.sv
// One shared first-order IIR over N_CH channels, served round-robin; IIR_SCHED_OVERRUN_CNT_EN adds the overrun counter.
// Latency: channel i result strobes 5(i+1) cycles after frame accept; frame busy 5M cycles (M enabled channels).
// Backpressure: in_ready low while busy or clearing; frames offered then are dropped, not held.
module iir_channel_scheduler #(
  parameter int Q_IN = 32,
  parameter int N_CH = 8,
  parameter int B1   = 409,
  parameter int B2   = 409,
  parameter int A2   = -64718
) (
  input logic                    clock,
  input logic                    reset,
  iir_channel_scheduler_if.slave bus
);
  localparam int ACC_W  = Q_IN + 20;
  localparam int PROD_W = Q_IN + 18;
  localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] MUL_X  = 3'd1;
  localparam logic [2:0] MUL_X1 = 3'd2;
  localparam logic [2:0] MUL_Y1 = 3'd3;
  localparam logic [2:0] DIV    = 3'd4;
  localparam logic [2:0] EMIT   = 3'd5;

  localparam logic signed [17:0] COEF_B1 = 18'(B1);
  localparam logic signed [17:0] COEF_B2 = 18'(B2);
  localparam logic signed [17:0] COEF_A2 = 18'(A2);

  logic [2:0]             state_q;
  logic [CH_W-1:0]        ch_q;
  logic [N_CH-1:0]        mask_q;
  logic signed [Q_IN-1:0] frame_q [N_CH];
  logic signed [Q_IN-1:0] x1_q    [N_CH];
  logic signed [Q_IN-1:0] y1_q    [N_CH];
  logic signed [ACC_W-1:0] acc_q;
  logic signed [Q_IN-1:0] y_q;
  logic                   clr_pend_q;

  logic                   out_valid_q;
  logic [3:0]             out_ch_q;
  logic signed [Q_IN-1:0] out_data_q;
  logic                   out_last_q;

  logic                   clr_req;
  logic                   in_ready;
  logic [CH_W-1:0]        first_ch;
  logic [CH_W-1:0]        nxt_ch;
  logic                   nxt_found;
  logic signed [Q_IN-1:0] mul_a;
  logic signed [17:0]     mul_b;
  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0] acc_adj;
  logic signed [Q_IN-1:0] y_div;

  // A pending or same-cycle clear owns the IDLE cycle, so no frame is accepted alongside it.
  assign clr_req  = bus.state_clr || clr_pend_q;
  assign in_ready = (state_q == IDLE) && !clr_req;

  always_comb begin
    first_ch = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (bus.ch_en[k]) first_ch = CH_W'(k);
    end
  end

  always_comb begin
    nxt_found = 1'b0;
    nxt_ch    = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (mask_q[k] && (k > int'(ch_q))) begin
        nxt_found = 1'b1;
        nxt_ch    = CH_W'(k);
      end
    end
  end

  always_comb begin
    mul_a = frame_q[ch_q];
    mul_b = COEF_B1;
    case (state_q)
      MUL_X1: begin
        mul_a = x1_q[ch_q];
        mul_b = COEF_B2;
      end
      MUL_Y1: begin
        mul_a = y1_q[ch_q];
        mul_b = COEF_A2;
      end
      default: ;
    endcase
  end

  assign prod = mul_a * mul_b;

  // Bias negative sums by 2^16-1 so the shift rounds toward zero like a true divide.
  assign acc_adj = acc_q[ACC_W-1] ? (acc_q + ACC_W'(65535)) : acc_q;
  assign y_div   = Q_IN'(acc_adj >>> 16);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      ch_q        <= '0;
      mask_q      <= '0;
      acc_q       <= '0;
      y_q         <= '0;
      clr_pend_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      for (int k = 0; k < N_CH; k++) begin
        frame_q[k] <= '0;
        x1_q[k]    <= '0;
        y1_q[k]    <= '0;
      end
    end else begin
      out_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (clr_req) begin
            clr_pend_q <= 1'b0;
            for (int k = 0; k < N_CH; k++) begin
              x1_q[k] <= '0;
              y1_q[k] <= '0;
            end
          end else if (bus.in_valid) begin
            for (int k = 0; k < N_CH; k++) begin
              frame_q[k] <= bus.in_data[k*Q_IN +: Q_IN];
            end
            mask_q  <= bus.ch_en;
            ch_q    <= first_ch;
            state_q <= MUL_X;
          end
        end
        MUL_X: begin
          if (mask_q == '0) begin
            state_q <= IDLE;
          end else begin
            acc_q   <= ACC_W'(prod);
            state_q <= MUL_X1;
          end
        end
        MUL_X1: begin
          acc_q   <= acc_q + ACC_W'(prod);
          state_q <= MUL_Y1;
        end
        MUL_Y1: begin
          acc_q   <= acc_q - ACC_W'(prod);
          state_q <= DIV;
        end
        DIV: begin
          y_q     <= y_div;
          state_q <= EMIT;
        end
        EMIT: begin
          out_valid_q <= 1'b1;
          out_data_q  <= y_q;
          out_ch_q    <= 4'(ch_q);
          out_last_q  <= !nxt_found;
          x1_q[ch_q]  <= frame_q[ch_q];
          y1_q[ch_q]  <= y_q;
          if (nxt_found) begin
            ch_q    <= nxt_ch;
            state_q <= MUL_X;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      if ((state_q != IDLE) && bus.state_clr) clr_pend_q <= 1'b1;
    end
  end

`ifdef IIR_SCHED_OVERRUN_CNT_EN
  logic [15:0] overrun_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overrun_q <= '0;
    end else if (bus.in_valid && !in_ready && (overrun_q != 16'hFFFF)) begin
      overrun_q <= overrun_q + 16'd1;
    end
  end

  assign bus.overrun_cnt = overrun_q;
`else
  assign bus.overrun_cnt = 16'd0;
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
endmodule

// File: tb/tb_iir_channel_scheduler.sv
// Bench for iir_channel_scheduler: directed frames from the test plan plus randomized frames checked
// against an arithmetic per-channel IIR model.
module tb_iir_channel_scheduler;
  localparam int Q  = 32;
  localparam int NC = 8;
  localparam longint B1 = 409;
  localparam longint B2 = 409;
  localparam longint A2 = -64718;
  localparam int WAIT_LIMIT = 200;

  logic clock = 1'b0;
  logic reset = 1'b0;

  iir_channel_scheduler_if #(.Q_IN(Q), .N_CH(NC)) bus ();

  iir_channel_scheduler #(.Q_IN(Q), .N_CH(NC)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int e0 = 0;
  int rdy_cyc = 0;

  always @(posedge clock) cyc++;

  int     obs_ch[$];
  longint obs_dat[$];
  bit     obs_last[$];
  int     obs_cyc[$];

  always @(negedge clock) begin
    if (reset && bus.out_valid === 1'b1) begin
      obs_ch.push_back(int'(bus.out_ch));
      obs_dat.push_back(longint'(bus.out_data));
      obs_last.push_back(bus.out_last);
      obs_cyc.push_back(cyc);
    end
  end

  // Reference: y = (B1*x + B2*x1 - A2*y1) / 2^16 with C-style division, wrapped to Q bits.
  longint m_x1[NC];
  longint m_y1[NC];
  int     exp_ch[$];
  longint exp_dat[$];
  bit     exp_last[$];

  function automatic void model_clear();
    for (int k = 0; k < NC; k++) begin
      m_x1[k] = 0;
      m_y1[k] = 0;
    end
  endfunction

  function automatic void model_frame(input logic [NC*Q-1:0] d, input logic [NC-1:0] m);
    int top;
    longint x;
    longint acc;
    longint y;
    top = -1;
    exp_ch.delete();
    exp_dat.delete();
    exp_last.delete();
    for (int k = 0; k < NC; k++) if (m[k]) top = k;
    for (int k = 0; k < NC; k++) begin
      if (m[k]) begin
        x   = longint'($signed(d[k*Q +: Q]));
        acc = B1 * x + B2 * m_x1[k] - A2 * m_y1[k];
        y   = longint'(int'(acc / 65536));
        exp_ch.push_back(k);
        exp_dat.push_back(y);
        exp_last.push_back(k == top);
        m_x1[k] = x;
        m_y1[k] = y;
      end
    end
  endfunction

  task automatic run_frame(input logic [NC*Q-1:0] d, input logic [NC-1:0] m);
    int n;
    obs_ch.delete();
    obs_dat.delete();
    obs_last.delete();
    obs_cyc.delete();
    n = 0;
    while (bus.in_ready !== 1'b1 && n < WAIT_LIMIT) begin
      @(negedge clock);
      n++;
    end
    bus.in_data  = d;
    bus.ch_en    = m;
    bus.in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    e0 = cyc;
    bus.in_valid = 1'b0;
    while (bus.in_ready !== 1'b1 && n < WAIT_LIMIT) begin
      @(negedge clock);
      n++;
    end
    rdy_cyc = cyc;
    checks++;
    if (n >= WAIT_LIMIT) begin
      errors++;
      $display("FAIL ready_timeout: in_ready=%b after %0d cycles, expected 1 within %0d", bus.in_ready, n, WAIT_LIMIT);
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic pulse_clr;
    bus.state_clr = 1'b1;
    @(negedge clock);
    bus.state_clr = 1'b0;
    @(negedge clock);
    model_clear();
  endtask

  function automatic logic [NC*Q-1:0] flat_frame(input logic [Q-1:0] v);
    logic [NC*Q-1:0] d;
    for (int k = 0; k < NC; k++) d[k*Q +: Q] = v;
    return d;
  endfunction

  task automatic test_reset;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.ch_en     = '0;
    bus.state_clr = 1'b0;
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready); end
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b, expected 0", bus.out_valid); end
    checks++;
    if (bus.out_ch !== 4'd0) begin errors++; $display("FAIL reset_out_ch: got %0d, expected 0", bus.out_ch); end
    checks++;
    if (bus.out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %0d, expected 0", bus.out_data); end
    checks++;
    if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b, expected 0", bus.out_last); end
    checks++;
    if (bus.overrun_cnt !== 16'd0) begin errors++; $display("FAIL reset_overrun: got %0d, expected 0", bus.overrun_cnt); end
    reset = 1'b1;
    model_clear();
    @(negedge clock);
  endtask

  task automatic test_full_frame;
    logic [NC*Q-1:0] d;
    longint want;
    d = flat_frame(32'd65536);
    for (int pass = 0; pass < 2; pass++) begin
      want = (pass == 0) ? 409 : 1221;
      model_frame(d, 8'hFF);
      run_frame(d, 8'hFF);
      checks++;
      if (obs_dat.size() != NC) begin
        errors++;
        $display("FAIL full%0d_count: got %0d outputs, expected %0d", pass, obs_dat.size(), NC);
      end
      for (int i = 0; i < obs_dat.size() && i < NC; i++) begin
        checks++;
        if (obs_ch[i] != i || obs_dat[i] != want || obs_last[i] != (i == NC - 1) || obs_cyc[i] != e0 + 5 * (i + 1)) begin
          errors++;
          $display("FAIL full%0d_out%0d: got ch=%0d dat=%0d last=%0d t=%0d, expected ch=%0d dat=%0d last=%0d t=%0d",
                   pass, i, obs_ch[i], obs_dat[i], obs_last[i], obs_cyc[i] - e0, i, want, (i == NC - 1), 5 * (i + 1));
        end
      end
      checks++;
      if (rdy_cyc - e0 != 5 * NC) begin
        errors++;
        $display("FAIL full%0d_ready: got %0d cycles, expected %0d", pass, rdy_cyc - e0, 5 * NC);
      end
    end
  endtask

  task automatic test_truncation;
    logic [NC*Q-1:0] d;
    longint want;
    for (int pass = 0; pass < 2; pass++) begin
      pulse_clr();
      d = '0;
      d[Q-1:0] = (pass == 0) ? 32'hFFFF_FFFF : 32'hFFFF_0000;
      want = (pass == 0) ? 0 : -409;
      model_frame(d, 8'h01);
      run_frame(d, 8'h01);
      checks++;
      if (obs_dat.size() != 1 || obs_ch[0] != 0 || obs_dat[0] != want || obs_last[0] != 1'b1 || obs_cyc[0] != e0 + 5) begin
        errors++;
        $display("FAIL trunc%0d: got n=%0d ch=%0d dat=%0d last=%0d t=%0d, expected n=1 ch=0 dat=%0d last=1 t=5",
                 pass, obs_dat.size(), obs_ch[0], obs_dat[0], obs_last[0], obs_cyc[0] - e0, want);
      end
    end
  endtask

  task automatic test_mask;
    logic [NC*Q-1:0] d;
    longint want;
    d = flat_frame(32'd65536);
    pulse_clr();
    model_frame(d, 8'h05);
    run_frame(d, 8'h05);
    checks++;
    if (obs_dat.size() != 2 || obs_ch[0] != 0 || obs_ch[1] != 2 || obs_dat[0] != 409 || obs_dat[1] != 409 ||
        obs_last[0] != 1'b0 || obs_last[1] != 1'b1 || obs_cyc[0] != e0 + 5 || obs_cyc[1] != e0 + 10) begin
      errors++;
      $display("FAIL mask05: got n=%0d ch=%0d,%0d dat=%0d,%0d last=%0d,%0d, expected n=2 ch=0,2 dat=409,409 last=0,1",
               obs_dat.size(), obs_ch[0], obs_ch[1], obs_dat[0], obs_dat[1], obs_last[0], obs_last[1]);
    end
    checks++;
    if (rdy_cyc - e0 != 10) begin errors++; $display("FAIL mask05_ready: got %0d cycles, expected 10", rdy_cyc - e0); end
    model_frame(d, 8'hFF);
    run_frame(d, 8'hFF);
    checks++;
    if (obs_dat.size() != NC) begin errors++; $display("FAIL mask_full_count: got %0d, expected %0d", obs_dat.size(), NC); end
    for (int i = 0; i < obs_dat.size() && i < NC; i++) begin
      want = (i == 0 || i == 2) ? 1221 : 409;
      checks++;
      if (obs_ch[i] != i || obs_dat[i] != want) begin
        errors++;
        $display("FAIL mask_full_out%0d: got ch=%0d dat=%0d, expected ch=%0d dat=%0d", i, obs_ch[i], obs_dat[i], i, want);
      end
    end
  endtask

  task automatic test_empty_mask;
    run_frame(flat_frame(32'd1234), '0);
    checks++;
    if (obs_dat.size() != 0 || rdy_cyc - e0 != 1) begin
      errors++;
      $display("FAIL empty_mask: got %0d outputs ready after %0d, expected 0 outputs ready after 1", obs_dat.size(), rdy_cyc - e0);
    end
  endtask

  task automatic test_state_clr;
    logic [NC*Q-1:0] d;
    d = flat_frame(32'd65536);
    model_frame(d, 8'hFF);
    fork
      run_frame(d, 8'hFF);
      begin
        repeat (12) @(negedge clock);
        bus.state_clr = 1'b1;
        @(negedge clock);
        bus.state_clr = 1'b0;
      end
    join
    checks++;
    if (obs_dat.size() != exp_dat.size()) begin
      errors++;
      $display("FAIL clr_inflight_count: got %0d, expected %0d", obs_dat.size(), exp_dat.size());
    end else begin
      for (int i = 0; i < exp_dat.size(); i++) begin
        checks++;
        if (obs_ch[i] != exp_ch[i] || obs_dat[i] != exp_dat[i]) begin
          errors++;
          $display("FAIL clr_inflight_out%0d: got ch=%0d dat=%0d, expected ch=%0d dat=%0d", i, obs_ch[i], obs_dat[i], exp_ch[i], exp_dat[i]);
        end
      end
    end
    model_clear();
    model_frame(d, 8'hFF);
    run_frame(d, 8'hFF);
    checks++;
    if (obs_dat.size() != NC) begin errors++; $display("FAIL clr_after_count: got %0d, expected %0d", obs_dat.size(), NC); end
    for (int i = 0; i < obs_dat.size() && i < NC; i++) begin
      checks++;
      if (obs_dat[i] != 409) begin errors++; $display("FAIL clr_after_out%0d: got %0d, expected 409", i, obs_dat[i]); end
    end
  endtask

  task automatic test_overrun;
    logic [NC*Q-1:0] d;
    int ov0;
    int exp_ov;
    d = flat_frame(32'd70000);
    ov0 = int'(bus.overrun_cnt);
    model_frame(d, 8'hFF);
    fork
      run_frame(d, 8'hFF);
      begin
        repeat (4) @(negedge clock);
        bus.in_valid = 1'b1;
        repeat (3) @(negedge clock);
        bus.in_valid = 1'b0;
      end
    join
    repeat (10) @(negedge clock);
`ifdef IIR_SCHED_OVERRUN_CNT_EN
    exp_ov = ov0 + 3;
`else
    exp_ov = 0;
`endif
    checks++;
    if (int'(bus.overrun_cnt) != exp_ov) begin
      errors++;
      $display("FAIL overrun_cnt: got %0d, expected %0d", bus.overrun_cnt, exp_ov);
    end
    checks++;
    if (obs_dat.size() != NC) begin
      errors++;
      $display("FAIL overrun_outputs: got %0d outputs, expected %0d", obs_dat.size(), NC);
    end
    for (int i = 0; i < obs_dat.size() && i < exp_dat.size(); i++) begin
      checks++;
      if (obs_ch[i] != exp_ch[i] || obs_dat[i] != exp_dat[i]) begin
        errors++;
        $display("FAIL overrun_out%0d: got ch=%0d dat=%0d, expected ch=%0d dat=%0d", i, obs_ch[i], obs_dat[i], exp_ch[i], exp_dat[i]);
      end
    end
  endtask

  task automatic test_reset_midframe;
    logic [NC*Q-1:0] d;
    d = flat_frame(32'd65536);
    bus.in_data  = d;
    bus.ch_en    = 8'hFF;
    bus.in_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.in_valid = 1'b0;
    repeat (7) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
      errors++;
      $display("FAIL midreset_outputs: got ready=%b valid=%b data=%0d, expected ready=1 valid=0 data=0",
               bus.in_ready, bus.out_valid, bus.out_data);
    end
    reset = 1'b1;
    @(negedge clock);
    model_clear();
    model_frame(d, 8'hFF);
    run_frame(d, 8'hFF);
    checks++;
    if (obs_dat.size() != NC) begin errors++; $display("FAIL midreset_count: got %0d, expected %0d", obs_dat.size(), NC); end
    for (int i = 0; i < obs_dat.size() && i < NC; i++) begin
      checks++;
      if (obs_dat[i] != 409) begin errors++; $display("FAIL midreset_out%0d: got %0d, expected 409", i, obs_dat[i]); end
    end
  endtask

  task automatic test_random;
    logic [NC*Q-1:0] d;
    logic [NC-1:0] m;
    int exp_rdy;
    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 5) == 0) pulse_clr();
      for (int k = 0; k < NC; k++) d[k*Q +: Q] = $urandom;
      m = NC'($urandom_range(0, (1 << NC) - 1));
      exp_rdy = (m == '0) ? 1 : 5 * $countones(m);
      model_frame(d, m);
      run_frame(d, m);
      checks++;
      if (obs_dat.size() != exp_dat.size()) begin
        errors++;
        $display("FAIL rand%0d_count: got %0d outputs, expected %0d (mask %h)", f, obs_dat.size(), exp_dat.size(), m);
      end else begin
        for (int i = 0; i < exp_dat.size(); i++) begin
          checks++;
          if (obs_ch[i] != exp_ch[i] || obs_dat[i] != exp_dat[i] || obs_last[i] != exp_last[i] || obs_cyc[i] != e0 + 5 * (i + 1)) begin
            errors++;
            $display("FAIL rand%0d_out%0d: got ch=%0d dat=%0d last=%0d t=%0d, expected ch=%0d dat=%0d last=%0d t=%0d",
                     f, i, obs_ch[i], obs_dat[i], obs_last[i], obs_cyc[i] - e0, exp_ch[i], exp_dat[i], exp_last[i], 5 * (i + 1));
          end
        end
      end
      checks++;
      if (rdy_cyc - e0 != exp_rdy) begin
        errors++;
        $display("FAIL rand%0d_ready: got %0d cycles, expected %0d", f, rdy_cyc - e0, exp_rdy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_truncation();
    test_mask();
    test_empty_mask();
    test_state_clr();
    test_overrun();
    test_reset_midframe();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $fatal(1, "watchdog expired");
  end
endmodule
